// File: rtl/spif_pkt_pkg.sv
// Shared definitions for the SpiNNaker multicast packet transmit path.
//   PACKET_BITS   : packet width ([71:40] payload, [39:8] key, [7:0] header)
//   HDR_*_BIT     : header bit positions (parity, payload-present)
//   KEY_LSB/PLD_LSB : field offsets inside the flat packet vector
//   src_e         : source tag carried with each buffered packet
//   pkt_t         : structured view of one packet
//   pkt_process() : payload zeroing and optional odd-parity regeneration
package spif_pkt_pkg;

  localparam int unsigned PACKET_BITS = 72;

  localparam int unsigned HDR_PTY_BIT = 0;
  localparam int unsigned HDR_PLD_BIT = 1;
  localparam int unsigned KEY_LSB     = 8;
  localparam int unsigned PLD_LSB     = 40;

  typedef enum logic {
    SRC_PER = 1'b0,
    SRC_DCP = 1'b1
  } src_e;

  typedef struct packed {
    logic [31:0] pld;
    logic [31:0] key;
    logic [7:0]  hdr;
  } pkt_t;

  // Clears the payload when the header says none is present, then (optionally)
  // rewrites the parity bit so that the whole 72-bit packet has odd parity.
  function automatic pkt_t pkt_process(input pkt_t p, input bit fix_parity);
    pkt_t r;
    r = p;
    if (!r.hdr[HDR_PLD_BIT]) begin
      r.pld = '0;
    end
    if (fix_parity) begin
      r.hdr[HDR_PTY_BIT] = ~^(r[PACKET_BITS-1:1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_tx_fifo.sv
// Two-entry output buffer for the packet transmitter.
//   clk, reset        : clock, synchronous active-high reset (empties buffer)
//   in_data/in_vld/in_rdy    : write side, push when in_vld && in_rdy
//   out_data/out_vld/out_rdy : read side, pop when out_vld && out_rdy
// Full and empty are registered; in_rdy = !full, out_vld = !empty. A push
// while full is never accepted, so a pop from a full buffer reopens the
// write side only one cycle later.
module pkt_tx_fifo #(
  parameter int unsigned WIDTH = 73
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push;
  logic             pop;

  assign in_rdy   = !full_q;
  assign out_vld  = !empty_q;
  assign out_data = mem_q[rd_ptr_q];

  assign push = in_vld && !full_q;
  assign pop  = !empty_q && out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == 2'd2);
    empty_d = (count_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

endmodule

// File: rtl/pkt_transmitter.sv
// Transmit-side merge of peripheral event packets and diagnostic counter
// reply (DCP) packets into one multicast stream towards the transceiver.
//   clk, reset                  : clock, synchronous active-high reset
//   per_data_in/vld_in/rdy_out  : peripheral packet input
//   dcp_data_in/vld_in/rdy_out  : DCP packet input
//   pkt_data_out/vld_out/rdy_in : outgoing packet stream
//   ptx_cnt_out                 : per-source sent enables ([0] PER, [1] DCP)
// Round-robin arbitration between the two sources, payload zeroing and
// parity regeneration on accept, two-entry output buffer.
module pkt_transmitter
  import spif_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS = spif_pkt_pkg::PACKET_BITS,
  parameter bit          FIX_PARITY  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] per_data_in,
  input  logic                   per_vld_in,
  output logic                   per_rdy_out,
  input  logic [PACKET_BITS-1:0] dcp_data_in,
  input  logic                   dcp_vld_in,
  output logic                   dcp_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  output logic [1:0]             ptx_cnt_out
);

  // Source served most recently; reset value makes the peripheral win the
  // first tie.
  src_e last_q, last_d;

  logic grant_per;
  logic grant_dcp;
  logic per_acc;
  logic dcp_acc;

  logic                 fifo_in_rdy;
  logic                 fifo_in_vld;
  logic [PACKET_BITS:0] fifo_in_data;
  logic [PACKET_BITS:0] fifo_out_data;
  logic                 fifo_out_vld;

  pkt_t sel_pkt;
  pkt_t proc_pkt;
  src_e sel_tag;
  src_e head_tag;
  logic tx_fire;

  // Arbiter pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SRC_DCP;
    end else begin
      last_q <= last_d;
    end
  end

  // Pointer moves only when an input transfer is actually accepted.
  always_comb begin
    last_d = last_q;
    if (per_acc) begin
      last_d = SRC_PER;
    end else if (dcp_acc) begin
      last_d = SRC_DCP;
    end
  end

  // Grant and ready. Grants are mutually exclusive by construction, so the
  // two ready outputs can never be high together.
  always_comb begin
    grant_per   = per_vld_in && (!dcp_vld_in || (last_q == SRC_DCP));
    grant_dcp   = dcp_vld_in && (!per_vld_in || (last_q == SRC_PER));
    per_rdy_out = grant_per && fifo_in_rdy && !reset;
    dcp_rdy_out = grant_dcp && fifo_in_rdy && !reset;
  end

  assign per_acc = per_vld_in && per_rdy_out;
  assign dcp_acc = dcp_vld_in && dcp_rdy_out;

  // Packet conditioning for whichever source holds the grant.
  always_comb begin
    sel_pkt      = grant_dcp ? pkt_t'(dcp_data_in) : pkt_t'(per_data_in);
    sel_tag      = grant_dcp ? SRC_DCP : SRC_PER;
    proc_pkt     = pkt_process(sel_pkt, FIX_PARITY);
    fifo_in_data = {sel_tag, proc_pkt};
    fifo_in_vld  = per_acc || dcp_acc;
  end

  pkt_tx_fifo #(
    .WIDTH (PACKET_BITS + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_data  (fifo_in_data),
    .in_vld   (fifo_in_vld),
    .in_rdy   (fifo_in_rdy),
    .out_data (fifo_out_data),
    .out_vld  (fifo_out_vld),
    .out_rdy  (pkt_rdy_in)
  );

  // Count enables follow the output handshake and the tag of the head entry.
  always_comb begin
    head_tag     = src_e'(fifo_out_data[PACKET_BITS]);
    pkt_data_out = fifo_out_data[PACKET_BITS-1:0];
    pkt_vld_out  = fifo_out_vld;
    tx_fire      = fifo_out_vld && pkt_rdy_in;
    ptx_cnt_out  = '0;
    ptx_cnt_out[0] = tx_fire && (head_tag == SRC_PER);
    ptx_cnt_out[1] = tx_fire && (head_tag == SRC_DCP);
  end

endmodule

// File: tb/tb_pkt_transmitter.sv
module tb_pkt_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] per_data, dcp_data;
  logic        per_vld, dcp_vld, pkt_rdy;
  logic        per_rdy, dcp_rdy, pkt_vld;
  logic [71:0] pkt_data;
  logic [1:0]  cnt;
  logic        np_per_rdy, np_dcp_rdy, np_vld;
  logic [71:0] np_data;
  logic [1:0]  np_cnt;

  always #5 clk = ~clk;

  pkt_transmitter #(.PACKET_BITS(72), .FIX_PARITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .per_data_in(per_data), .per_vld_in(per_vld), .per_rdy_out(per_rdy),
    .dcp_data_in(dcp_data), .dcp_vld_in(dcp_vld), .dcp_rdy_out(dcp_rdy),
    .pkt_data_out(pkt_data), .pkt_vld_out(pkt_vld), .pkt_rdy_in(pkt_rdy),
    .ptx_cnt_out(cnt)
  );

  pkt_transmitter #(.PACKET_BITS(72), .FIX_PARITY(1'b0)) dut_np (
    .clk(clk), .reset(reset),
    .per_data_in(per_data), .per_vld_in(per_vld), .per_rdy_out(np_per_rdy),
    .dcp_data_in(dcp_data), .dcp_vld_in(dcp_vld), .dcp_rdy_out(np_dcp_rdy),
    .pkt_data_out(np_data), .pkt_vld_out(np_vld), .pkt_rdy_in(pkt_rdy),
    .ptx_cnt_out(np_cnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conditioning: zero payload if hdr[1]==0, then odd parity over all 72 bits.
  function automatic logic [71:0] proc(input logic [71:0] d, input bit fix);
    logic [71:0] r;
    r = d;
    if (r[1] == 1'b0) r[71:40] = '0;
    if (fix) r[0] = ~(^r[71:1]);
    return r;
  endfunction

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[71:0];
  endfunction

  typedef struct {
    logic        pv;
    logic [71:0] pd;
    logic        dv;
    logic [71:0] dd;
    logic        rdy;
    logic        e_prdy;
    logic        e_drdy;
    logic        e_vld;
    logic [71:0] e_data;
    logic [1:0]  e_cnt;
    logic        chk_np;
    logic [71:0] e_np;
  } vec_t;

  vec_t vt[13];

  // Scoreboard state shared by the multi-cycle sequences.
  logic [72:0] sbq[$];
  logic        hold_prev;
  logic [71:0] held_data;
  logic        per_took, dcp_took;
  int unsigned sent, per_in, dcp_in, per_out, dcp_out;

  task automatic mon();
    logic [72:0] e;
    check("rdy_onehot", {1'b0, per_rdy & dcp_rdy}, 0);
    if (hold_prev) begin
      check("hold_vld", pkt_vld, 1);
      check("hold_data", pkt_data, held_data);
    end
    if (pkt_vld && pkt_rdy) begin
      check("sb_nonempty", (sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_data", pkt_data, e[71:0]);
        check("sb_cnt", cnt, e[72] ? 2'b10 : 2'b01);
      end
      sent++;
      if (cnt[0]) per_out++;
      if (cnt[1]) dcp_out++;
    end else begin
      check("cnt_idle", cnt, 0);
    end
    hold_prev = pkt_vld && !pkt_rdy;
    held_data = pkt_data;
    per_took  = per_vld && per_rdy;
    dcp_took  = dcp_vld && dcp_rdy;
    if (per_took) begin sbq.push_back({1'b0, proc(per_data, 1'b1)}); per_in++; end
    if (dcp_took) begin sbq.push_back({1'b1, proc(dcp_data, 1'b1)}); dcp_in++; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [71:0] a_in, a_out, d_in, d_out;
    logic [71:0] p1, q1, p2, q2, p3, q3;
    int unsigned acc, cyc;
    bit gen;

    a_in  = {32'hAAAA_5555, 32'h1234_5678, 8'h00};
    a_out = {32'h0000_0000, 32'h1234_5678, 8'h00};
    d_in  = {32'hdead_beef, 32'hffff_0043, 8'h02};
    d_out = {32'hdead_beef, 32'hffff_0043, 8'h03};
    p1 = {32'h1, 32'h0, 8'h03};
    q1 = {32'h0, 32'h1, 8'h03};
    p2 = {32'h3, 32'h0, 8'h02};
    q2 = {32'h0, 32'h3, 8'h02};
    p3 = {32'h7, 32'h0, 8'h03};
    q3 = {32'h0, 32'h7, 8'h03};

    //        pv  pd    dv  dd    rdy prdy drdy vld data   cnt    np  np_data
    vt[0]  = '{1, a_in, 0, 72'h0, 1,  1,   0,   0,  72'h0, 2'b00, 0, 72'h0};
    vt[1]  = '{0, 72'h0, 1, d_in, 1,  0,   1,   1,  a_out, 2'b01, 1, a_out};
    vt[2]  = '{0, 72'h0, 0, 72'h0, 0, 0,   0,   1,  d_out, 2'b00, 1, d_in};
    vt[3]  = '{0, 72'h0, 0, 72'h0, 1, 0,   0,   1,  d_out, 2'b10, 1, d_in};
    vt[4]  = '{0, 72'h0, 0, 72'h0, 1, 0,   0,   0,  72'h0, 2'b00, 0, 72'h0};
    vt[5]  = '{1, p1,   1, q1,    1,  1,   0,   0,  72'h0, 2'b00, 0, 72'h0};
    vt[6]  = '{1, p2,   1, q1,    1,  0,   1,   1,  p1,    2'b01, 0, 72'h0};
    vt[7]  = '{1, p2,   1, q2,    1,  1,   0,   1,  q1,    2'b10, 0, 72'h0};
    vt[8]  = '{1, p3,   1, q2,    0,  0,   1,   1,  p2,    2'b00, 0, 72'h0};
    vt[9]  = '{1, p3,   1, q3,    0,  0,   0,   1,  p2,    2'b00, 0, 72'h0};
    vt[10] = '{1, p3,   1, q3,    1,  0,   0,   1,  p2,    2'b01, 0, 72'h0};
    vt[11] = '{0, 72'h0, 0, 72'h0, 1, 0,   0,   1,  q2,    2'b10, 0, 72'h0};
    vt[12] = '{0, 72'h0, 0, 72'h0, 1, 0,   0,   0,  72'h0, 2'b00, 0, 72'h0};

    // Reset state, with requests present to show ready stays low in reset.
    reset = 1'b1; per_vld = 1'b1; dcp_vld = 1'b1; pkt_rdy = 1'b1;
    per_data = p1; dcp_data = q1;
    tick(); tick();
    check("rst_vld", pkt_vld, 0);
    check("rst_data", pkt_data, 0);
    check("rst_cnt", cnt, 0);
    check("rst_per_rdy", per_rdy, 0);
    check("rst_dcp_rdy", dcp_rdy, 0);
    reset = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < 13; i++) begin
      per_vld = vt[i].pv; per_data = vt[i].pd;
      dcp_vld = vt[i].dv; dcp_data = vt[i].dd;
      pkt_rdy = vt[i].rdy;
      #1;
      check($sformatf("v%0d_per_rdy", i), per_rdy, vt[i].e_prdy);
      check($sformatf("v%0d_dcp_rdy", i), dcp_rdy, vt[i].e_drdy);
      check($sformatf("v%0d_vld", i), pkt_vld, vt[i].e_vld);
      if (vt[i].e_vld) check($sformatf("v%0d_data", i), pkt_data, vt[i].e_data);
      check($sformatf("v%0d_cnt", i), cnt, vt[i].e_cnt);
      if (vt[i].chk_np) check($sformatf("v%0d_np_data", i), np_data, vt[i].e_np);
      tick();
    end

    // Reset mid-stream with two buffered packets; PER served last before reset.
    per_vld = 1'b0; dcp_vld = 1'b1; dcp_data = q1; pkt_rdy = 1'b0;
    #1; check("mr_dcp_rdy", dcp_rdy, 1);
    tick();
    per_vld = 1'b1; per_data = p1; dcp_vld = 1'b0;
    #1; check("mr_per_rdy", per_rdy, 1);
    tick();
    per_vld = 1'b1; dcp_vld = 1'b1; dcp_data = q2; per_data = p2;
    check("mr_full_vld", pkt_vld, 1);
    reset = 1'b1;
    #1;
    check("mr_in_rst_per_rdy", per_rdy, 0);
    check("mr_in_rst_dcp_rdy", dcp_rdy, 0);
    tick();
    reset = 1'b0; pkt_rdy = 1'b1;
    #1;
    check("mr_vld", pkt_vld, 0);
    check("mr_cnt", cnt, 0);
    check("mr_tie_per", per_rdy, 1);
    check("mr_tie_dcp", dcp_rdy, 0);
    tick();
    per_vld = 1'b0; dcp_vld = 1'b0;
    #1;
    check("mr_first_data", pkt_data, p2);
    check("mr_first_cnt", cnt, 2'b01);
    tick();
    #1; check("mr_empty", pkt_vld, 0);

    // Output stalled for 5 cycles with both sources valid.
    sbq.delete(); hold_prev = 1'b0; acc = 0;
    sent = 0; per_in = 0; dcp_in = 0; per_out = 0; dcp_out = 0;
    per_vld = 1'b1; per_data = p3; dcp_vld = 1'b1; dcp_data = q3; pkt_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1; mon();
      if (per_took || dcp_took) acc++;
      tick();
      if (per_took) per_data = rnd72();
      if (dcp_took) dcp_data = rnd72();
    end
    check("stall_accepts", acc, 2);
    check("stall_per_rdy", per_rdy, 0);
    check("stall_dcp_rdy", dcp_rdy, 0);
    per_vld = 1'b0; dcp_vld = 1'b0; pkt_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; mon(); tick();
    end
    check("stall_drained", sent, 2);
    check("stall_sb_empty", sbq.size(), 0);

    // Random vld/rdy stress with scoreboard.
    sbq.delete(); hold_prev = 1'b0;
    sent = 0; per_in = 0; dcp_in = 0; per_out = 0; dcp_out = 0;
    gen = 1'b1; cyc = 0;
    per_vld = 1'b0; dcp_vld = 1'b0; pkt_rdy = 1'b1;
    while (cyc < 60000) begin
      #1; mon();
      tick();
      cyc++;
      if (sent >= 10000) gen = 1'b0;
      if (!gen) begin
        per_vld = 1'b0; dcp_vld = 1'b0; pkt_rdy = 1'b1;
        if (sbq.size() == 0 && !pkt_vld) break;
      end else begin
        if (!per_vld || per_took) begin per_vld = ($urandom_range(0, 3) != 0); per_data = rnd72(); end
        if (!dcp_vld || dcp_took) begin dcp_vld = ($urandom_range(0, 3) != 0); dcp_data = rnd72(); end
        pkt_rdy = ($urandom_range(0, 3) != 0);
      end
    end
    check("stress_finished", (sent >= 10000 && sbq.size() == 0), 1);
    check("stress_per_count", per_out, per_in);
    check("stress_dcp_count", dcp_out, dcp_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
